// File: rtl/gpu_pkg.sv
// Shared GPU types and screen geometry used by the pixel writer and its neighbours.
package gpu_pkg;

    localparam int unsigned WIDTH_BITS   = 10;
    localparam int unsigned HEIGHT_BITS  = 9;
    localparam int unsigned CHANNEL_BITS = 8;
    localparam int unsigned SCREEN_W     = 640;
    localparam int unsigned SCREEN_H     = 480;

    typedef struct packed {
        logic [WIDTH_BITS-1:0]   x;
        logic [HEIGHT_BITS-1:0]  y;
        logic [CHANNEL_BITS-1:0] r;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] b;
    } pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } writer_state_t;

endpackage

// File: rtl/gpu_pixel_writer_if.sv
// Pixel input stream and framebuffer SRAM write port of the pixel writer.
interface gpu_pixel_writer_if #(
    parameter int unsigned WIDTH_BITS   = gpu_pkg::WIDTH_BITS,
    parameter int unsigned HEIGHT_BITS  = gpu_pkg::HEIGHT_BITS,
    parameter int unsigned CHANNEL_BITS = gpu_pkg::CHANNEL_BITS,
    parameter int unsigned ADDR_BITS    = 20
);

    logic                      pixel_valid_i;
    logic [WIDTH_BITS-1:0]     x_i;
    logic [HEIGHT_BITS-1:0]    y_i;
    logic [CHANNEL_BITS-1:0]   r_i;
    logic [CHANNEL_BITS-1:0]   g_i;
    logic [CHANNEL_BITS-1:0]   b_i;
    logic                      pixel_ready_o;
    logic [ADDR_BITS-1:0]      frame_base_i;
    logic [ADDR_BITS-1:0]      mem_addr_o;
    logic [3*CHANNEL_BITS-1:0] mem_wdata_o;
    logic                      mem_we_o;
    logic                      mem_ack_i;
    logic                      drop_o;
    logic                      idle_o;

    modport slave (
        input  pixel_valid_i, x_i, y_i, r_i, g_i, b_i, frame_base_i, mem_ack_i,
        output pixel_ready_o, mem_addr_o, mem_wdata_o, mem_we_o, drop_o, idle_o
    );

    modport master (
        output pixel_valid_i, x_i, y_i, r_i, g_i, b_i, frame_base_i, mem_ack_i,
        input  pixel_ready_o, mem_addr_o, mem_wdata_o, mem_we_o, drop_o, idle_o
    );

endinterface

// File: rtl/gpu_pixel_fifo.sv
// Generic synchronous FIFO; extra pointer MSB distinguishes full from empty.
module gpu_pixel_fifo #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gpu_pixel_writer.sv
// Buffers on-screen pixels, converts them to linear framebuffer addresses and
// issues one SRAM write per ack, in acceptance order.
module gpu_pixel_writer #(
    parameter int unsigned WIDTH_BITS   = gpu_pkg::WIDTH_BITS,
    parameter int unsigned HEIGHT_BITS  = gpu_pkg::HEIGHT_BITS,
    parameter int unsigned CHANNEL_BITS = gpu_pkg::CHANNEL_BITS,
    parameter int unsigned SCREEN_W     = gpu_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H     = gpu_pkg::SCREEN_H,
    parameter int unsigned ADDR_BITS    = 20,
    parameter int unsigned DEPTH        = 4
) (
    input logic              clk,
    input logic              rst,
    gpu_pixel_writer_if.slave bus
);

    localparam int unsigned COLOR_BITS = 3 * CHANNEL_BITS;
    localparam int unsigned DATA_BITS  = ADDR_BITS + COLOR_BITS;

    gpu_pkg::writer_state_t state, state_next;

    logic                  on_screen;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_BITS-1:0]  pix_addr;
    logic [DATA_BITS-1:0]  fifo_wdata;
    logic [DATA_BITS-1:0]  fifo_rdata;
    logic                  we_q, we_next;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [COLOR_BITS-1:0] wdata_q;
    logic                  drop_q;

    assign on_screen  = (32'(bus.x_i) < SCREEN_W) && (32'(bus.y_i) < SCREEN_H);
    assign accept     = bus.pixel_valid_i && !fifo_full;
    assign push       = accept && on_screen;
    // Address arithmetic deliberately wraps at ADDR_BITS.
    assign pix_addr   = bus.frame_base_i
                      + ADDR_BITS'(bus.y_i) * ADDR_BITS'(SCREEN_W)
                      + ADDR_BITS'(bus.x_i);
    assign fifo_wdata = {pix_addr, bus.r_i, bus.g_i, bus.b_i};

    gpu_pixel_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        we_next    = we_q;
        case (state)
            gpu_pkg::IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    we_next    = 1'b1;
                    state_next = gpu_pkg::WRITE;
                end
            end
            gpu_pkg::WRITE: begin
                if (bus.mem_ack_i) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        we_next    = 1'b0;
                        state_next = gpu_pkg::IDLE;
                    end
                end
            end
            default: state_next = gpu_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= gpu_pkg::IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state  <= state_next;
            we_q   <= we_next;
            drop_q <= accept && !on_screen;
            if (pop) {addr_q, wdata_q} <= fifo_rdata;
        end
    end

    assign bus.pixel_ready_o = !fifo_full;
    assign bus.mem_we_o      = we_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_wdata_o   = wdata_q;
    assign bus.drop_o        = drop_q;
    assign bus.idle_o        = (state == gpu_pkg::IDLE) && fifo_empty;

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed bench for gpu_pixel_writer: single-pixel vector table plus stall,
// concurrent push/pop and mid-write reset sequences.
module tb_gpu_pixel_writer;
    import gpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gpu_pixel_writer_if #(.ADDR_BITS(20)) bus ();

    gpu_pixel_writer #(
        .ADDR_BITS (20),
        .DEPTH     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        pixel_t      pix;
        logic [19:0] base;
        logic        exp_drop;
        logic [19:0] exp_addr;
        logic [23:0] exp_wdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input pixel_t p, input logic [19:0] base);
        bus.x_i           = p.x;
        bus.y_i           = p.y;
        bus.r_i           = p.r;
        bus.g_i           = p.g;
        bus.b_i           = p.b;
        bus.frame_base_i  = base;
        bus.pixel_valid_i = 1'b1;
    endtask

    function automatic pixel_t mk(input int x, input int y, input int c);
        pixel_t p;
        p.x = WIDTH_BITS'(x);
        p.y = HEIGHT_BITS'(y);
        p.r = CHANNEL_BITS'(c);
        p.g = CHANNEL_BITS'(c + 1);
        p.b = CHANNEL_BITS'(c + 2);
        return p;
    endfunction

    initial begin
        logic [19:0] exp_addr[6];

        vecs[0] = '{pix: '{x: 10'd3,    y: 9'd2,   r: 8'hFF, g: 8'h80, b: 8'h01}, base: 20'h00000,
                    exp_drop: 1'b0, exp_addr: 20'd1283,  exp_wdata: 24'hFF8001};
        vecs[1] = '{pix: '{x: 10'd640,  y: 9'd0,   r: 8'h11, g: 8'h22, b: 8'h33}, base: 20'h00000,
                    exp_drop: 1'b1, exp_addr: 20'd0,     exp_wdata: 24'h0};
        vecs[2] = '{pix: '{x: 10'd0,    y: 9'd480, r: 8'h44, g: 8'h55, b: 8'h66}, base: 20'h00000,
                    exp_drop: 1'b1, exp_addr: 20'd0,     exp_wdata: 24'h0};
        vecs[3] = '{pix: '{x: 10'd639,  y: 9'd479, r: 8'h12, g: 8'h34, b: 8'h56}, base: 20'h4B000,
                    exp_drop: 1'b0, exp_addr: 20'h95FFF, exp_wdata: 24'h123456};
        vecs[4] = '{pix: '{x: 10'd1,    y: 9'd0,   r: 8'hAB, g: 8'hCD, b: 8'hEF}, base: 20'hFFFFF,
                    exp_drop: 1'b0, exp_addr: 20'h00000, exp_wdata: 24'hABCDEF};
        vecs[5] = '{pix: '{x: 10'd1023, y: 9'd511, r: 8'h01, g: 8'h02, b: 8'h03}, base: 20'h00000,
                    exp_drop: 1'b1, exp_addr: 20'd0,     exp_wdata: 24'h0};
        vecs[6] = '{pix: '{x: 10'd639,  y: 9'd0,   r: 8'h00, g: 8'hFF, b: 8'h00}, base: 20'h00000,
                    exp_drop: 1'b0, exp_addr: 20'd639,   exp_wdata: 24'h00FF00};
        vecs[7] = '{pix: '{x: 10'd0,    y: 9'd479, r: 8'h0F, g: 8'hF0, b: 8'h5A}, base: 20'h00000,
                    exp_drop: 1'b0, exp_addr: 20'h4AD80, exp_wdata: 24'h0FF05A};

        bus.pixel_valid_i = 1'b0;
        bus.x_i = '0; bus.y_i = '0; bus.r_i = '0; bus.g_i = '0; bus.b_i = '0;
        bus.frame_base_i = '0;
        bus.mem_ack_i = 1'b0;

        tick();
        tick();
        check("rst_we",    32'(bus.mem_we_o), 0);
        check("rst_addr",  32'(bus.mem_addr_o), 0);
        check("rst_wdata", 32'(bus.mem_wdata_o), 0);
        check("rst_drop",  32'(bus.drop_o), 0);
        check("rst_ready", 32'(bus.pixel_ready_o), 1);
        check("rst_idle",  32'(bus.idle_o), 1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].pix, vecs[i].base);
            tick();
            bus.pixel_valid_i = 1'b0;
            if (vecs[i].exp_drop) begin
                check($sformatf("v%0d_drop", i), 32'(bus.drop_o), 1);
                check($sformatf("v%0d_we0", i), 32'(bus.mem_we_o), 0);
                tick();
                check($sformatf("v%0d_drop_end", i), 32'(bus.drop_o), 0);
                check($sformatf("v%0d_we1", i), 32'(bus.mem_we_o), 0);
                check($sformatf("v%0d_idle", i), 32'(bus.idle_o), 1);
            end else begin
                check($sformatf("v%0d_nodrop", i), 32'(bus.drop_o), 0);
                check($sformatf("v%0d_we_early", i), 32'(bus.mem_we_o), 0);
                check($sformatf("v%0d_busy", i), 32'(bus.idle_o), 0);
                tick();
                check($sformatf("v%0d_we", i), 32'(bus.mem_we_o), 1);
                check($sformatf("v%0d_addr", i), 32'(bus.mem_addr_o), 32'(vecs[i].exp_addr));
                check($sformatf("v%0d_wdata", i), 32'(bus.mem_wdata_o), 32'(vecs[i].exp_wdata));
                bus.mem_ack_i = 1'b1;
                tick();
                bus.mem_ack_i = 1'b0;
                check($sformatf("v%0d_we_done", i), 32'(bus.mem_we_o), 0);
                check($sformatf("v%0d_idle", i), 32'(bus.idle_o), 1);
            end
        end

        // Stall: no acks, six offers; the sixth must be refused.
        for (int i = 0; i < 6; i++) exp_addr[i] = 20'(i * 640 + 10 + i);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stall_ready%0d", i), 32'(bus.pixel_ready_o), (i < 5) ? 1 : 0);
            drive(mk(10 + i, i, 16 * i), 20'h0);
            tick();
        end
        bus.pixel_valid_i = 1'b0;
        check("stall_full", 32'(bus.pixel_ready_o), 0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_we%0d", k), 32'(bus.mem_we_o), 1);
            check($sformatf("stall_addr%0d", k), 32'(bus.mem_addr_o), 32'(exp_addr[k]));
            bus.mem_ack_i = 1'b1;
            tick();
        end
        bus.mem_ack_i = 1'b0;
        check("stall_we_done", 32'(bus.mem_we_o), 0);
        check("stall_ready",   32'(bus.pixel_ready_o), 1);
        check("stall_idle",    32'(bus.idle_o), 1);

        // Two queued entries behind an outstanding write; push lands with an ack-pop.
        drive(mk(1, 0, 1), 20'h100); tick();
        drive(mk(2, 0, 2), 20'h100); tick();
        drive(mk(3, 0, 3), 20'h100); tick();
        bus.pixel_valid_i = 1'b0;
        check("pp_addr_a", 32'(bus.mem_addr_o), 32'h101);
        bus.mem_ack_i = 1'b1;
        drive(mk(4, 0, 4), 20'h100);
        tick();
        bus.pixel_valid_i = 1'b0;
        check("pp_we_b",   32'(bus.mem_we_o), 1);
        check("pp_addr_b", 32'(bus.mem_addr_o), 32'h102);
        check("pp_ready",  32'(bus.pixel_ready_o), 1);
        tick();
        check("pp_addr_c", 32'(bus.mem_addr_o), 32'h103);
        tick();
        check("pp_addr_d",  32'(bus.mem_addr_o), 32'h104);
        check("pp_wdata_d", 32'(bus.mem_wdata_o), 32'h040506);
        tick();
        bus.mem_ack_i = 1'b0;
        check("pp_we_done", 32'(bus.mem_we_o), 0);
        check("pp_idle",    32'(bus.idle_o), 1);

        // Reset with a write outstanding and three entries queued.
        for (int i = 0; i < 4; i++) begin
            drive(mk(20 + i, 1, 32 + i), 20'h0);
            tick();
        end
        bus.pixel_valid_i = 1'b0;
        check("mr_we_before",   32'(bus.mem_we_o), 1);
        check("mr_idle_before", 32'(bus.idle_o), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_we",    32'(bus.mem_we_o), 0);
        check("mr_idle",  32'(bus.idle_o), 1);
        check("mr_ready", 32'(bus.pixel_ready_o), 1);
        check("mr_addr",  32'(bus.mem_addr_o), 0);
        bus.mem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mr_quiet%0d", i), 32'(bus.mem_we_o), 0);
        end
        bus.mem_ack_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
